sopc_2_motor_seq: RTL and testbench

SOPC_2_MOTOR_SEQ -- requirements
Module: sopc_2_motor_seq

---
 rtl/sopc_2_motor_pkg.sv | 16 +
 rtl/sopc_2_motor_seq_if.sv | 10 +
 rtl/sopc_2_motor_step_gen.sv | 79 +++++++
 rtl/sopc_2_motor_seq.sv | 105 ++++++++++
 tb/tb_sopc_2_motor_seq.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/sopc_2_motor_pkg.sv
// sopc_2_motor_pkg: register map, CTRL/STATUS bit positions and step FSM states
package sopc_2_motor_pkg;
    localparam int ADDR_CTRL    = 0;
    localparam int ADDR_STEPS   = 1;
    localparam int ADDR_PERIOD  = 2;
    localparam int ADDR_STATUS  = 3;
    localparam int CTRL_START   = 0;
    localparam int CTRL_DIR     = 1;
    localparam int CTRL_EN      = 2;
    localparam int CTRL_ABORT   = 3;
    localparam int CTRL_IRQ_EN  = 4;
    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_REM_LSB = 16;
    typedef enum logic [1:0] {IDLE, STEP_HI, STEP_LO} state_e;
endpackage

// File: rtl/sopc_2_motor_seq_if.sv
// sopc_2_motor_seq_if: Avalon-MM slave bus of the motor sequencer
interface sopc_2_motor_seq_if #(parameter int ADDR_W = 2);
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/sopc_2_motor_step_gen.sv
// sopc_2_motor_step_gen: half-period timer and STEP_HI/STEP_LO pulse sequencer
module sopc_2_motor_step_gen
    import sopc_2_motor_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [CNT_W-1:0] steps_i,
    input  logic [CNT_W-1:0] period_i,
    output logic             step_o,
    output logic             busy_o,
    output logic             fin_o,
    output logic [CNT_W-1:0] remaining_o
);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             expire;

    // A timer value of 0 or 1 ends the phase, so PERIOD=0 still gives one clock
    assign expire      = timer_q <= CNT_W'(1);
    assign step_o      = state_q == STEP_HI;
    assign busy_o      = state_q != IDLE;
    assign remaining_o = rem_q;

    // Next-state, timer reload/decrement and step countdown; abort overrides all
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        rem_d   = rem_q;
        fin_o   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = STEP_HI;
                    timer_d = period_i;
                    rem_d   = steps_i;
                end
            end
            STEP_HI: begin
                state_d = expire ? STEP_LO : STEP_HI;
                timer_d = expire ? period_i : timer_q - CNT_W'(1);
            end
            STEP_LO: begin
                if (expire) begin
                    timer_d = period_i;
                    rem_d   = (rem_q != '0) ? rem_q - CNT_W'(1) : rem_q;
                    state_d = (rem_q <= CNT_W'(1)) ? IDLE : STEP_HI;
                    fin_o   = rem_q <= CNT_W'(1);
                end else begin
                    timer_d = timer_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort_i) begin
            state_d = IDLE;
            timer_d = timer_q;
            rem_d   = rem_q;
            fin_o   = 1'b0;
        end
    end

    // State, timer and remaining-count registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            rem_q   <= rem_d;
        end
    end
endmodule

// File: rtl/sopc_2_motor_seq.sv
// sopc_2_motor_seq: Avalon-MM register file driving a step/dir motor sequencer
module sopc_2_motor_seq
    import sopc_2_motor_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int ADDR_W = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    sopc_2_motor_seq_if.slave   bus,
    output logic                step,
    output logic                dir,
    output logic                drv_en,
    output logic                irq
);
    logic [ADDR_W-1:0] addr;
    logic              wr, ctrl_wr, start_w, go, null_start, abort, done_clr;
    logic              busy, fin;
    logic [CNT_W-1:0]  remaining;
    logic              ctrl_dir_q, ctrl_dir_d, ctrl_en_q, ctrl_en_d, irq_en_q, irq_en_d;
    logic              done_q, done_d, dir_q, dir_d;
    logic [CNT_W-1:0]  steps_q, steps_d, period_q, period_d;
    logic [31:0]       rdata;

    assign addr       = bus.address;
    assign wr         = bus.chipselect & ~bus.write_n;
    assign ctrl_wr    = wr && addr == ADDR_W'(ADDR_CTRL);
    // Abort in the same write cancels the start entirely
    assign start_w    = ctrl_wr & bus.writedata[CTRL_START] & ~bus.writedata[CTRL_ABORT];
    // Enable is taken from the same write so one CTRL write can enable and start
    assign go         = start_w & ~busy & bus.writedata[CTRL_EN] & (steps_q != '0);
    assign null_start = start_w & ~busy & ~go;
    assign abort      = busy & ctrl_wr & (bus.writedata[CTRL_ABORT] | ~bus.writedata[CTRL_EN]);
    assign done_clr   = wr && addr == ADDR_W'(ADDR_STATUS) && bus.writedata[STAT_DONE];

    sopc_2_motor_step_gen #(.CNT_W(CNT_W)) u_step_gen (
        .clk         (clk),
        .reset_n     (reset_n),
        .start_i     (go),
        .abort_i     (abort),
        .steps_i     (steps_q),
        .period_i    (period_q),
        .step_o      (step),
        .busy_o      (busy),
        .fin_o       (fin),
        .remaining_o (remaining)
    );

    // Register write decode; done set beats any clear in the same cycle
    always_comb begin
        ctrl_dir_d = ctrl_wr ? bus.writedata[CTRL_DIR] : ctrl_dir_q;
        ctrl_en_d  = ctrl_wr ? bus.writedata[CTRL_EN] : ctrl_en_q;
        irq_en_d   = ctrl_wr ? bus.writedata[CTRL_IRQ_EN] : irq_en_q;
        steps_d    = (wr && addr == ADDR_W'(ADDR_STEPS)) ? bus.writedata[CNT_W-1:0] : steps_q;
        period_d   = (wr && addr == ADDR_W'(ADDR_PERIOD)) ? bus.writedata[CNT_W-1:0] : period_q;
        dir_d      = go ? bus.writedata[CTRL_DIR] : dir_q;
        done_d     = (null_start | fin) ? 1'b1 : (go | done_clr) ? 1'b0 : done_q;
    end

    // Register file
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_dir_q <= 1'b0;
            ctrl_en_q  <= 1'b0;
            irq_en_q   <= 1'b0;
            steps_q    <= '0;
            period_q   <= '0;
            dir_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            ctrl_dir_q <= ctrl_dir_d;
            ctrl_en_q  <= ctrl_en_d;
            irq_en_q   <= irq_en_d;
            steps_q    <= steps_d;
            period_q   <= period_d;
            dir_q      <= dir_d;
            done_q     <= done_d;
        end
    end

    // Zero-wait-state read mux; write-1-pulse bits and unmapped bits read 0
    always_comb begin
        rdata = '0;
        case (addr)
            ADDR_W'(ADDR_CTRL): begin
                rdata[CTRL_DIR]    = ctrl_dir_q;
                rdata[CTRL_EN]     = ctrl_en_q;
                rdata[CTRL_IRQ_EN] = irq_en_q;
            end
            ADDR_W'(ADDR_STEPS):  rdata = 32'(steps_q);
            ADDR_W'(ADDR_PERIOD): rdata = 32'(period_q);
            ADDR_W'(ADDR_STATUS): begin
                rdata[STAT_BUSY]            = busy;
                rdata[STAT_DONE]            = done_q;
                rdata[31:STAT_REM_LSB]      = 16'(remaining);
            end
            default: rdata = '0;
        endcase
    end

    assign bus.readdata = rdata;
    assign dir          = busy ? dir_q : ctrl_dir_q;
    assign drv_en       = ctrl_en_q;
    assign irq          = done_q & irq_en_q;
endmodule

// File: tb/tb_sopc_2_motor_seq.sv
// tb_sopc_2_motor_seq: randomized and directed checks against an arithmetic pulse-train model
module tb_sopc_2_motor_seq;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic step, dir, drv_en, irq;
    int   errors = 0;
    int   checks = 0;

    sopc_2_motor_seq_if #(.ADDR_W(2)) bus ();

    sopc_2_motor_seq #(.CNT_W(16), .ADDR_W(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave),
        .step    (step),
        .dir     (dir),
        .drv_en  (drv_en),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic wr(input int a, input int d);
        bus.address    = 2'(a);
        bus.writedata  = 32'(d);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic rd(input int a, output logic [31:0] v);
        bus.address = 2'(a);
        #1;
        v = bus.readdata;
    endtask

    task automatic start_move(input int n, input int p, input int ctrl);
        wr(1, n);
        wr(2, p);
        wr(0, ctrl);
    endtask

    // Model: a move of n pulses with half-period h occupies 2*n*h clocks after the
    // start write; step is high in the first h clocks of each 2*h window, and the
    // remaining count drops by one at the end of every completed window.
    task automatic watch(input int n, input int h, input bit d, input int k0, input int k1);
        logic [31:0] v;
        int          tot;
        bit          b;
        for (int k = k0; k < k1; k++) begin
            tot = 2 * n * h;
            b   = k < tot;
            check("step", 32'(step), 32'(b && ((k % (2 * h)) < h)));
            if (b) check("dir", 32'(dir), 32'(d));
            rd(3, v);
            check("busy", 32'(v[0]), 32'(b));
            check("remaining", 32'(v[31:16]), 32'(b ? n - k / (2 * h) : 0));
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [31:0] v;
        int n, p, h, ie;
        bit d;
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        #12;
        for (int a = 0; a < 4; a++) begin
            rd(a, v);
            check("reset_reg", v, 0);
        end
        check("reset_outs", {28'd0, step, dir, drv_en, irq}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Three pulses, 2 high / 2 low, dir=1, 12 busy clocks then done
        start_move(3, 2, 32'h07);
        watch(3, 2, 1'b1, 0, 14);
        rd(3, v);
        check("done_3x2", 32'(v[1]), 1);
        check("drv_en_on", 32'(drv_en), 1);

        // Single 1-clock pulse with irq, then clear done
        wr(3, 2);
        start_move(1, 0, 32'h15);
        watch(1, 1, 1'b0, 0, 3);
        check("irq_set", 32'(irq), 1);
        wr(3, 2);
        check("irq_clr", 32'(irq), 0);

        // Abort at the start of the 4th pulse
        start_move(10, 4, 32'h07);
        watch(10, 4, 1'b1, 0, 24);
        check("step_before_abort", 32'(step), 1);
        wr(0, 32'h0C);
        check("abort_step", 32'(step), 0);
        rd(3, v);
        check("abort_busy", 32'(v[0]), 0);
        check("abort_done", 32'(v[1]), 0);
        check("abort_rem", 32'(v[31:16]), 7);
        @(posedge clk);
        #1;
        check("abort_step_hold", 32'(step), 0);

        // Start and STEPS write while busy do not disturb the move
        start_move(4, 1, 32'h07);
        watch(4, 1, 1'b1, 0, 4);
        wr(1, 5);
        wr(0, 32'h05);
        watch(4, 1, 1'b1, 6, 10);
        rd(3, v);
        check("busy_wr_done", 32'(v[1]), 1);
        rd(1, v);
        check("busy_wr_steps", v, 5);
        check("idle_dir_ctrl", 32'(dir), 0);

        // Done set on completion beats a same-cycle clear
        wr(3, 2);
        start_move(2, 1, 32'h07);
        watch(2, 1, 1'b1, 0, 3);
        wr(3, 2);
        rd(3, v);
        check("set_wins", 32'(v[1]), 1);

        // Start with STEPS=0 sets done and stays idle
        wr(3, 2);
        wr(1, 0);
        wr(0, 32'h05);
        rd(3, v);
        check("zero_steps", v, 32'h2);
        check("zero_steps_step", 32'(step), 0);

        // Start with enable=0 sets done and stays idle
        wr(3, 2);
        wr(1, 3);
        wr(0, 32'h01);
        rd(3, v);
        check("no_enable", v, 32'h2);
        check("no_enable_drv", 32'(drv_en), 0);

        // Start+abort+enable from idle: nothing happens
        wr(3, 2);
        wr(0, 32'h0D);
        rd(3, v);
        check("start_abort_status", v, 0);
        rd(0, v);
        check("start_abort_ctrl", v, 32'h04);
        @(posedge clk);
        #1;
        check("start_abort_step", 32'(step), 0);

        // Clearing enable mid-move aborts
        start_move(3, 2, 32'h07);
        watch(3, 2, 1'b1, 0, 2);
        wr(0, 32'h02);
        rd(3, v);
        check("disable_status", v, 32'h0003_0000);
        check("disable_step", 32'(step), 0);
        check("disable_dir", 32'(dir), 1);

        // Randomized moves
        for (int i = 0; i < 12; i++) begin
            n  = $urandom_range(1, 5);
            p  = $urandom_range(0, 3);
            d  = 1'($urandom_range(0, 1));
            ie = $urandom_range(0, 1);
            h  = (p < 1) ? 1 : p;
            start_move(n, p, 32'h05 | (int'(d) << 1) | (ie << 4));
            watch(n, h, d, 0, 2 * n * h + 2);
            rd(3, v);
            check("rand_done", 32'(v[1]), 1);
            check("rand_irq", 32'(irq), 32'(ie));
            check("rand_dir", 32'(dir), 32'(d));
            wr(3, 2);
            check("rand_irq_clr", 32'(irq), 0);
        end

        // Reset asserted during STEP_HI
        start_move(5, 3, 32'h17);
        watch(5, 3, 1'b1, 0, 1);
        check("pre_reset_step", 32'(step), 1);
        reset_n = 1'b0;
        #1;
        check("reset_step", 32'(step), 0);
        for (int a = 0; a < 4; a++) begin
            rd(a, v);
            check("midreset_reg", v, 0);
        end
        check("midreset_outs", {28'd0, step, dir, drv_en, irq}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            check("post_reset_step", 32'(step), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
